// File: rtl/hartslag_regelaar_pkg.sv
// Shared types and defaults for the heart-rate speed regulator and its periodic helpers.
package hartslag_regelaar_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  localparam int unsigned DEF_START_SPEED = 128;
  localparam int unsigned DEF_MIN_SPEED   = 16;
  localparam int unsigned DEF_MAX_SPEED   = 240;
  localparam int unsigned DEF_MIN_HR      = 40;
  localparam int unsigned DEF_MAX_HR      = 220;

  // Sum of 2^avg_log2 eight-bit samples never overflows this width.
  function automatic int unsigned acc_width(input int unsigned avg_log2);
    return 8 + avg_log2;
  endfunction

endpackage

// File: rtl/hartslag_regelaar_tik_generator.sv
// Free-running sample tick: one-cycle pulse every SAMPLE_CYCLES clocks, first one
// SAMPLE_CYCLES cycles after reset release.
module tik_generator #(
  parameter int unsigned SAMPLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hartslag_regelaar.sv
// Closes the heart-rate loop: averages periodic rate samples and steps the rocking
// divider toward the target, falling back to a default speed when the signal is lost.
//
// state   | meaning
// INIT    | clear average, load start speed (1 cycle)
// MEASURE | accumulate plausible samples on tick, count implausible runs
// ADJUST  | compare average with target, step speed (1 cycle)
// LOST    | hold start speed, wait for a run of plausible samples
module hartslag_regelaar
  import hartslag_regelaar_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 1000000,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned START_SPEED   = DEF_START_SPEED,
  parameter int unsigned MIN_SPEED     = DEF_MIN_SPEED,
  parameter int unsigned MAX_SPEED     = DEF_MAX_SPEED,
  parameter int unsigned STEP          = 4,
  parameter int unsigned TOL           = 2,
  parameter int unsigned MIN_HR        = DEF_MIN_HR,
  parameter int unsigned MAX_HR        = DEF_MAX_HR,
  parameter int unsigned LOST_COUNT    = 3,
  parameter int unsigned RECOVER_COUNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hartslag,
  input  logic [7:0] doel_hartslag,
  output logic [7:0] ClockSnelheid,
  output logic       geregeld,
  output logic       kwijt
);

  localparam int unsigned AW   = acc_width(AVG_LOG2);
  localparam int unsigned CNTW = AVG_LOG2 + 1;
  localparam int unsigned LW   = $clog2(LOST_COUNT + 1);
  localparam int unsigned RW   = $clog2(RECOVER_COUNT + 1);

  state_t          r_state;
  logic [7:0]      r_speed;
  logic            r_geregeld;
  logic            r_kwijt;
  logic [AW-1:0]   r_acc;
  logic [CNTW-1:0] r_cnt;
  logic [LW-1:0]   r_inv_run;
  logic [RW-1:0]   r_rec_run;

  logic            w_tick;
  logic            w_valid;
  logic [CNTW-1:0] w_cnt_next;
  logic [LW-1:0]   w_inv_next;
  logic [RW-1:0]   w_rec_next;
  logic [9:0]      w_avg;
  logic [9:0]      w_doel;
  logic [9:0]      w_hi;
  logic [9:0]      w_lo;
  logic [8:0]      w_up9;
  logic [7:0]      w_up;
  logic [7:0]      w_dn;

  tik_generator #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_tik (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_valid    = (hartslag >= 8'(MIN_HR)) && (hartslag <= 8'(MAX_HR));
  assign w_cnt_next = r_cnt + CNTW'(1);
  assign w_inv_next = r_inv_run + LW'(1);
  assign w_rec_next = r_rec_run + RW'(1);

  // 10-bit compare so the dead band neither wraps above 255 nor below 0.
  assign w_avg  = 10'(r_acc >> AVG_LOG2);
  assign w_doel = {2'b00, doel_hartslag};
  assign w_hi   = w_doel + 10'(TOL);
  assign w_lo   = (w_doel >= 10'(TOL)) ? (w_doel - 10'(TOL)) : 10'd0;

  assign w_up9 = {1'b0, r_speed} + 9'(STEP);
  assign w_up  = (w_up9 > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : w_up9[7:0];
  assign w_dn  = ({1'b0, r_speed} < 9'(MIN_SPEED + STEP)) ? 8'(MIN_SPEED) : (r_speed - 8'(STEP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_speed    <= 8'(START_SPEED);
      r_geregeld <= 1'b0;
      r_kwijt    <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_inv_run  <= '0;
      r_rec_run  <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_speed <= 8'(START_SPEED);
          r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_tick) begin
            if (w_valid) begin
              r_acc     <= r_acc + AW'(hartslag);
              r_cnt     <= w_cnt_next;
              r_inv_run <= '0;
              if (w_cnt_next == CNTW'(1 << AVG_LOG2)) r_state <= ST_ADJUST;
            end else if (w_inv_next == LW'(LOST_COUNT)) begin
              r_state    <= ST_LOST;
              r_speed    <= 8'(START_SPEED);
              r_kwijt    <= 1'b1;
              r_geregeld <= 1'b0;
              r_inv_run  <= '0;
              r_rec_run  <= '0;
            end else begin
              r_inv_run <= w_inv_next;
            end
          end
        end
        ST_ADJUST: begin
          if (w_avg > w_hi) begin
            r_speed    <= w_up;
            r_geregeld <= 1'b0;
          end else if (w_avg < w_lo) begin
            r_speed    <= w_dn;
            r_geregeld <= 1'b0;
          end else begin
            r_geregeld <= 1'b1;
          end
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= ST_MEASURE;
        end
        ST_LOST: begin
          if (w_tick) begin
            if (!w_valid) begin
              r_rec_run <= '0;
            end else if (w_rec_next == RW'(RECOVER_COUNT)) begin
              r_rec_run <= '0;
              r_kwijt   <= 1'b0;
              r_state   <= ST_INIT;
            end else begin
              r_rec_run <= w_rec_next;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign ClockSnelheid = r_speed;
  assign geregeld      = r_geregeld;
  assign kwijt         = r_kwijt;

endmodule

// File: tb/tb_hartslag_regelaar.sv
// Bench for hartslag_regelaar with an 8-cycle sample period: table of per-sample vectors
// through an expected-value queue, plus saturation and asynchronous reset sequences.
module tb_hartslag_regelaar;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hartslag;
  logic [7:0] doel_hartslag;
  logic [7:0] ClockSnelheid;
  logic       geregeld;
  logic       kwijt;

  always #5 clk = ~clk;

  hartslag_regelaar #(.SAMPLE_CYCLES(8), .AVG_LOG2(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .hartslag      (hartslag),
    .doel_hartslag (doel_hartslag),
    .ClockSnelheid (ClockSnelheid),
    .geregeld      (geregeld),
    .kwijt         (kwijt)
  );

  typedef struct {
    logic [7:0] hr;
    logic [7:0] doel;
    logic [7:0] spd;
    logic       ger;
    logic       kw;
  } vec_t;

  typedef struct {
    logic [7:0] spd;
    logic       ger;
    logic       kw;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic add(input int hr, input int doel, input int spd, input int ger, input int kw);
    tbl.push_back('{8'(hr), 8'(doel), 8'(spd), 1'(ger), 1'(kw)});
  endtask

  task automatic add_n(input int n, input int hr, input int doel, input int spd, input int ger,
                       input int kw);
    for (int i = 0; i < n; i++) add(hr, doel, spd, ger, kw);
  endtask

  // Starts 1ns after the edge following a capture edge; ends at the same phase one sample later.
  task automatic sample(input logic [7:0] hr, input logic [7:0] doel, input logic [7:0] spd,
                        input logic ger, input logic kw, input string tag);
    exp_t e;
    hartslag      = hr;
    doel_hartslag = doel;
    exp_q.push_back('{spd, ger, kw});
    repeat (8) @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".speed"}, ClockSnelheid, e.spd);
      chk({tag, ".geregeld"}, {7'd0, geregeld}, {7'd0, e.ger});
      chk({tag, ".kwijt"}, {7'd0, kwijt}, {7'd0, e.kw});
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk({tag, ".speed"}, ClockSnelheid, 8'd128);
    chk({tag, ".geregeld"}, {7'd0, geregeld}, 8'd0);
    chk({tag, ".kwijt"}, {7'd0, kwijt}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int m;
    reset         = 1'b0;
    hartslag      = 8'd100;
    doel_hartslag = 8'd100;

    // Per-sample vectors: {hartslag, doel, speed, geregeld, kwijt} seen after each capture.
    add_n(3, 100, 100, 128, 0, 0);  add(100, 100, 128, 1, 0);
    add_n(3, 120, 100, 128, 1, 0);  add(120, 100, 132, 0, 0);
    add_n(3, 120, 100, 132, 0, 0);  add(120, 100, 136, 0, 0);
    add_n(3, 120, 100, 136, 0, 0);  add(120, 100, 140, 0, 0);
    add(100, 100, 140, 0, 0);       add(0, 100, 140, 0, 0);
    add(100, 100, 140, 0, 0);       add(250, 100, 140, 0, 0);
    add(100, 100, 140, 0, 0);       add(100, 100, 140, 1, 0);
    add_n(2, 0, 100, 140, 1, 0);    add(0, 100, 128, 0, 1);
    add(100, 100, 128, 0, 1);       add(100, 100, 128, 0, 0);
    add_n(3, 90, 100, 128, 0, 0);   add(90, 100, 124, 0, 0);
    add(40, 85, 124, 0, 0);         add(39, 85, 124, 0, 0);
    add(40, 85, 124, 0, 0);         add(221, 85, 124, 0, 0);
    add(40, 85, 124, 0, 0);         add(220, 85, 124, 1, 0);
    add_n(4, 102, 100, 124, 1, 0);
    add_n(3, 98, 100, 124, 1, 0);   add(97, 100, 120, 0, 0);
    add_n(3, 103, 100, 120, 0, 0);  add(103, 100, 124, 0, 0);
    add_n(3, 220, 254, 124, 0, 0);  add(220, 254, 120, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.speed", ClockSnelheid, 8'd128);
    chk("reset.geregeld", {7'd0, geregeld}, 8'd0);
    chk("reset.kwijt", {7'd0, kwijt}, 8'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      sample(tbl[i].hr, tbl[i].doel, tbl[i].spd, tbl[i].ger, tbl[i].kw, $sformatf("vec%0d", i));

    m = 120;
    for (int a = 0; a < 40; a++)
      for (int s = 0; s < 4; s++) begin
        if (s == 3) m = (m + 4 > 240) ? 240 : m + 4;
        sample(8'd200, 8'd60, 8'(m), 1'b0, 1'b0, $sformatf("sat_up%0d", a));
      end
    for (int a = 0; a < 60; a++)
      for (int s = 0; s < 4; s++) begin
        if (s == 3) m = (m - 4 < 16) ? 16 : m - 4;
        sample(8'd50, 8'd200, 8'(m), 1'b0, 1'b0, $sformatf("sat_dn%0d", a));
      end

    async_reset("rst_a");
    for (int i = 0; i < 8; i++)
      sample(8'd120, 8'd100, (i < 3) ? 8'd128 : (i < 7) ? 8'd132 : 8'd136, 1'b0, 1'b0,
             $sformatf("climb%0d", i));
    for (int i = 0; i < 2; i++)
      sample(8'd120, 8'd100, 8'd136, 1'b0, 1'b0, $sformatf("mid%0d", i));
    async_reset("rst_b");

    // Third capture after release falls on edge 24 only if the tick counter restarted.
    hartslag = 8'd0;
    repeat (22) @(posedge clk);
    #1;
    chk("tick_phase.kwijt_early", {7'd0, kwijt}, 8'd0);
    @(posedge clk);
    #1;
    chk("tick_phase.kwijt_on", {7'd0, kwijt}, 8'd1);
    chk("tick_phase.speed", ClockSnelheid, 8'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hartslag_regelaar.md
Name: hartslag_regelaar

Overview:
- Downstream of the heart-rhythm stage: consumes the measured heart rate `hartslag` and closes the loop by producing `ClockSnelheid` for the clock-delay stage.
- Samples the rate periodically, averages it, and compares it with a target, stepping the rocking divider up or down.
- Detects loss of a plausible signal and restarts regulation from a known default speed.

Parameters:
- SAMPLE_CYCLES, 1000000, clk cycles between samples; must be >= 4.
- AVG_LOG2, 2, log2 of the number of samples averaged per adjustment.
- START_SPEED, 128, `ClockSnelheid` after reset, INIT and LOST.
- MIN_SPEED, 16, lower saturation bound of `ClockSnelheid`.
- MAX_SPEED, 240, upper saturation bound of `ClockSnelheid`.
- STEP, 4, `ClockSnelheid` increment/decrement per adjustment.
- TOL, 2, dead band in bpm around the target.
- MIN_HR, 40, lowest plausible `hartslag`.
- MAX_HR, 220, highest plausible `hartslag`.
- LOST_COUNT, 3, consecutive implausible samples that force LOST.
- RECOVER_COUNT, 2, consecutive plausible samples that leave LOST.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- hartslag  in  8  measured heart rate in bpm, from the heart-rhythm stage.
- doel_hartslag  in  8  target heart rate in bpm.
- ClockSnelheid  out  8  divider setting for the clock-delay stage; larger value = slower rocking.
- geregeld  out  1  high while the last average was within ±TOL of the target.
- kwijt  out  1  high while in LOST.

Behaviour:
- Reset (`reset`=0, asynchronous): `ClockSnelheid`=START_SPEED, `geregeld`=0, `kwijt`=0, state INIT, tick counter=0, accumulator=0, all run counters=0.
- Tick generator:
  - Free-running counter 0..SAMPLE_CYCLES-1; `tick` is high in the cycle where the count equals SAMPLE_CYCLES-1.
  - First tick is SAMPLE_CYCLES cycles after reset release.
  - `hartslag` is sampled only on `tick`.
- Plausibility: a sample is valid iff MIN_HR <= `hartslag` <= MAX_HR.
- States: INIT, MEASURE, ADJUST, LOST.
- INIT (1 cycle): clear accumulator and sample count; `ClockSnelheid`=START_SPEED; go to MEASURE.
- MEASURE, on tick:
  - Valid sample: add to accumulator (width 8+AVG_LOG2, cannot overflow); increment sample count; clear invalid run.
  - Invalid sample: not accumulated; increment invalid run.
  - When invalid run reaches LOST_COUNT: go to LOST. This takes priority over average completion.
  - When sample count reaches 2^AVG_LOG2: go to ADJUST.
- ADJUST (1 cycle):
  - avg = accumulator >> AVG_LOG2 (truncating); `doel_hartslag` is sampled in this cycle only.
  - avg > doel+TOL: `ClockSnelheid` = min(`ClockSnelheid`+STEP, MAX_SPEED); `geregeld`=0.
  - avg < doel-TOL: `ClockSnelheid` = max(`ClockSnelheid`-STEP, MIN_SPEED); `geregeld`=0.
  - Otherwise: `ClockSnelheid` unchanged; `geregeld`=1.
  - Compare in 10-bit unsigned, so doel+TOL does not wrap and doel-TOL floors at 0.
  - Clear accumulator and sample count; return to MEASURE.
  - The invalid run is not cleared here.
- LOST:
  - On entry (same clock edge as the transition): `ClockSnelheid`=START_SPEED, `kwijt`=1, `geregeld`=0.
  - On tick, a valid sample increments the recover run; an invalid sample clears it.
  - When the recover run reaches RECOVER_COUNT: `kwijt`=0, go to INIT.
- Output update latency: `ClockSnelheid`/`geregeld` change on the edge ending ADJUST, i.e. 2 cycles after the completing tick cycle. `kwijt` sets on the edge ending the tick cycle of the LOST_COUNT-th invalid sample.
- Tick never coincides with INIT or ADJUST, since SAMPLE_CYCLES >= 4 and both states last 1 cycle after a tick or reset. No tick drop logic is required.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding (INIT/MEASURE/ADJUST/LOST, 2 bits);
  - default constants for START_SPEED, MIN_SPEED, MAX_SPEED, MIN_HR, MAX_HR;
  - the accumulator width function 8+AVG_LOG2.
- One sub-module: `tik_generator` (SAMPLE_CYCLES parameter, outputs 1-cycle `tick`). It is reused by other periodic stages.

Test Plan (SAMPLE_CYCLES=8, AVG_LOG2=2, other defaults):
1. Reset release, `hartslag`=100, `doel_hartslag`=100 -> `ClockSnelheid`=128, `geregeld`=0, `kwijt`=0 until the 4th tick; 2 cycles after the 4th tick `geregeld`=1 and `ClockSnelheid` stays 128.
2. `hartslag`=120, `doel_hartslag`=100 -> `ClockSnelheid` 132 after tick 4, 136 after tick 8, 140 after tick 12; `geregeld`=0 throughout.
3. `hartslag`=200, `doel_hartslag`=60, run 40 averages -> `ClockSnelheid` climbs in steps of 4 and saturates at 240, never exceeds it; `hartslag`=50, `doel_hartslag`=200 saturates at 16.
4. While `ClockSnelheid`=140, drive `hartslag`=0 for 3 ticks -> `kwijt`=1 and `ClockSnelheid`=128 on the edge after the 3rd tick. Then `hartslag`=100 for 2 ticks -> `kwijt`=0, INIT, and a fresh 4-sample average.
5. Mixed samples 100, 0, 100, 250, 100, 100 with `doel_hartslag`=100 -> no LOST (invalid run never reaches 3); the average uses only the valid 100s; `geregeld`=1 after the 4th valid sample.
6. Assert `reset` mid-MEASURE with `ClockSnelheid`=136 -> outputs return to 128/0/0 immediately, without waiting for a clk edge. After release, the first tick comes 8 cycles later.
